router_fsm: RTL and testbench

- Packet-level controller for the 1x3 router; sits directly upstream of the synchroniser and register blocks.
- Decodes the header address and sequences header, payload and parity loads.
- Drives detect_add / write_enb_reg into the synchroniser; consumes fifo_full and per-port soft_reset from it.
- Stalls the source via busy while the destination FIFO is full or not yet drained.

---
 rtl/router_fsm_if.sv | 48 ++++
 rtl/router_fsm.sv | 112 +++++++++++
 tb/tb_router_fsm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM and its synchroniser/register neighbours.
// pkt_count exists only when ROUTER_FSM_PKT_CNT_EN is defined.
interface router_fsm_if #(
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] datain;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;
`ifdef ROUTER_FSM_PKT_CNT_EN
  logic [7:0]        pkt_count;
`endif

  modport master (
    output pkt_valid, datain, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy
`ifdef ROUTER_FSM_PKT_CNT_EN
    , input pkt_count
`endif
  );

  modport slave (
    input  pkt_valid, datain, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy
`ifdef ROUTER_FSM_PKT_CNT_EN
    , output pkt_count
`endif
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-level controller of the 1x3 router: header decode, payload/parity load sequencing.
// Optional completed-packet counter enabled by ROUTER_FSM_PKT_CNT_EN.
module router_fsm #(
  parameter int              ADDR_W       = 2,
  parameter logic [ADDR_W-1:0] INVALID_ADDR = 2'b11
) (
  input  logic         clk,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [(1<<ADDR_W)-1:0] empty_vec, srst_vec;
  logic                addr_ok;
  logic                srst_sel;

  always_comb begin
    empty_vec    = '0;
    srst_vec     = '0;
    empty_vec[0] = bus.fifo_empty_0;
    empty_vec[1] = bus.fifo_empty_1;
    empty_vec[2] = bus.fifo_empty_2;
    srst_vec[0]  = bus.soft_reset_0;
    srst_vec[1]  = bus.soft_reset_1;
    srst_vec[2]  = bus.soft_reset_2;
  end

  assign addr_ok  = bus.pkt_valid && (bus.datain != INVALID_ADDR);
  assign srst_sel = srst_vec[addr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && addr_ok)
        addr_q <= bus.datain;
    end
  end

  always_comb begin
    state_nxt = state;
    // Soft reset of the addressed port overrides every other transition.
    if (state != DECODE_ADDRESS && srst_sel) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      unique case (state)
        DECODE_ADDRESS:
          if (addr_ok)
            state_nxt = empty_vec[bus.datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_vec[addr_q]) state_nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_nxt = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
          else                        state_nxt = LOAD_DATA;
        LOAD_PARITY:
          state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    bus.detect_add    = (state == DECODE_ADDRESS);
    bus.lfd_state     = (state == LOAD_FIRST_DATA);
    bus.ld_state      = (state == LOAD_DATA);
    bus.laf_state     = (state == LOAD_AFTER_FULL);
    bus.full_state    = (state == FIFO_FULL_STATE);
    bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
    bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

`ifdef ROUTER_FSM_PKT_CNT_EN
  logic [7:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pkt_cnt_q <= '0;
    else if (state == CHECK_PARITY_ERROR && state_nxt == DECODE_ADDRESS && !srst_sel)
      pkt_cnt_q <= pkt_cnt_q + 8'd1;
  end

  assign bus.pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed plus randomized bench for router_fsm against a phase-table reference model.
module tb_router_fsm;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  router_fsm_if #(.ADDR_W(2)) bus ();

  router_fsm #(.ADDR_W(2), .INVALID_ADDR(2'b11)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 decode, 1 wait-empty, 2 first-data, 3 data, 4 full,
  // 5 after-full, 6 parity, 7 check-parity.
  int m_phase;
  int m_addr;
  int m_cnt;

  // Expected {detect,lfd,ld,laf,full,we,rst_int,busy} per phase.
  logic [7:0] exp_tab [8];

  initial begin
    exp_tab[0] = 8'b1000_0000;
    exp_tab[1] = 8'b0000_0001;
    exp_tab[2] = 8'b0100_0001;
    exp_tab[3] = 8'b0010_0100;
    exp_tab[4] = 8'b0000_1001;
    exp_tab[5] = 8'b0001_0101;
    exp_tab[6] = 8'b0000_0101;
    exp_tab[7] = 8'b0000_0011;
  end

  task automatic check(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
           bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    exp = exp_tab[m_phase];
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s outputs got=%b exp=%b (phase %0d)", tag, got, exp, m_phase);
    end
`ifdef ROUTER_FSM_PKT_CNT_EN
    total++;
    assert (bus.pkt_count === 8'(m_cnt)) else begin
      bad++;
      $error("FAIL %s pkt_count got=%0d exp=%0d", tag, bus.pkt_count, m_cnt);
    end
`endif
  endtask

  task automatic step(input string tag);
    int  nxt;
    int  d;
    bit  emp [3];
    bit  srs [3];
    bit  abort;
    emp[0] = bus.fifo_empty_0; emp[1] = bus.fifo_empty_1; emp[2] = bus.fifo_empty_2;
    srs[0] = bus.soft_reset_0; srs[1] = bus.soft_reset_1; srs[2] = bus.soft_reset_2;
    d      = int'(bus.datain);
    abort  = (m_phase != 0) && srs[m_addr];
    nxt    = m_phase;
    if (abort) nxt = 0;
    else begin
      case (m_phase)
        0: if (bus.pkt_valid && d != 3) nxt = emp[d] ? 2 : 1;
        1: if (emp[m_addr]) nxt = 2;
        2: nxt = 3;
        3: nxt = bus.fifo_full ? 4 : (!bus.pkt_valid ? 6 : 3);
        4: nxt = bus.fifo_full ? 4 : 5;
        5: nxt = bus.parity_done ? 0 : (bus.low_pkt_valid ? 6 : 3);
        6: nxt = 7;
        7: nxt = bus.fifo_full ? 4 : 0;
        default: nxt = 0;
      endcase
    end
    @(posedge clk);
    if (m_phase == 0 && bus.pkt_valid && d != 3) m_addr = d;
    if (m_phase == 7 && nxt == 0 && !abort) m_cnt = (m_cnt + 1) % 256;
    m_phase = nxt;
    #1;
    check(tag);
  endtask

  task automatic idle();
    bus.pkt_valid = 0; bus.datain = 2'd0; bus.fifo_full = 0;
    bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
    bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
    bus.parity_done = 0; bus.low_pkt_valid = 0;
  endtask

  task automatic min_packet(input logic [1:0] a, input string tag);
    bus.pkt_valid = 1; bus.datain = a; step({tag, "_hdr"});
    step({tag, "_lfd"});
    bus.pkt_valid = 0; step({tag, "_ld"});
    step({tag, "_lp"});
    step({tag, "_cpe"});
  endtask

  initial begin
    total = 0; bad = 0;
    m_phase = 0; m_addr = 0; m_cnt = 0;
    idle();
    resetn = 0;
    #12;
    check("reset");
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    // Minimum packet to port 1; busy only in LFD/LP/CPE.
    min_packet(2'd1, "min");
    step("min_idle");

    // Port 2 not empty for 4 cycles.
    bus.fifo_empty_2 = 0; bus.pkt_valid = 1; bus.datain = 2'd2;
    step("wte_enter");
    for (int i = 0; i < 3; i++) step("wte_hold");
    bus.fifo_empty_2 = 1; step("wte_exit");
    step("wte_ld");

    // FIFO full in LD for 3 cycles, low_pkt_valid path to parity.
    bus.fifo_full = 1;
    for (int i = 0; i < 3; i++) step("full_hold");
    bus.fifo_full = 0; step("laf");
    bus.low_pkt_valid = 1; step("laf_lp");
    bus.low_pkt_valid = 0; bus.pkt_valid = 0; step("laf_cpe");
    step("laf_dec");

    // Second full episode, parity_done exits straight to decode.
    bus.pkt_valid = 1; bus.datain = 2'd0; step("pd_hdr");
    step("pd_lfd");
    bus.fifo_full = 1; step("pd_full");
    bus.fifo_full = 0; step("pd_laf");
    bus.parity_done = 1; bus.low_pkt_valid = 1; step("pd_dec");
    idle();

    // Soft reset: only the latched port matters.
    bus.fifo_empty_0 = 0; bus.pkt_valid = 1; bus.datain = 2'd0; step("sr_wte");
    bus.pkt_valid = 0; bus.soft_reset_1 = 1; step("sr_other");
    bus.soft_reset_1 = 0; bus.soft_reset_0 = 1; step("sr_own");
    idle();

    // Invalid address is ignored.
    bus.pkt_valid = 1; bus.datain = 2'd3;
    for (int i = 0; i < 5; i++) step("addr3");
    idle();

    // Asynchronous reset in the middle of LOAD_DATA.
    bus.pkt_valid = 1; bus.datain = 2'd1; step("ar_hdr");
    step("ar_lfd");
    bus.pkt_valid = 1; step("ar_ld");
    #3 resetn = 0;
    #1;
    m_phase = 0; m_addr = 0; m_cnt = 0;
    check("async_rst");
    idle();
    @(negedge clk) resetn = 1;
    step("ar_after");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.pkt_valid     = ($urandom_range(0, 3) != 0);
      bus.datain        = 2'($urandom_range(0, 3));
      bus.fifo_full     = ($urandom_range(0, 3) == 0);
      bus.fifo_empty_0  = ($urandom_range(0, 2) != 0);
      bus.fifo_empty_1  = ($urandom_range(0, 2) != 0);
      bus.fifo_empty_2  = ($urandom_range(0, 2) != 0);
      bus.soft_reset_0  = ($urandom_range(0, 15) == 0);
      bus.soft_reset_1  = ($urandom_range(0, 15) == 0);
      bus.soft_reset_2  = ($urandom_range(0, 15) == 0);
      bus.parity_done   = ($urandom_range(0, 3) == 0);
      bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // Fresh reset, then 256 clean packets wrap the counter.
    idle();
    @(negedge clk) resetn = 0;
    m_phase = 0; m_addr = 0; m_cnt = 0;
    @(negedge clk) resetn = 1;
    for (int i = 0; i < 256; i++) min_packet(2'(i % 3), "wrap");
`ifdef ROUTER_FSM_PKT_CNT_EN
    total++;
    assert (bus.pkt_count === 8'd0) else begin
      bad++;
      $error("FAIL wrap_final pkt_count got=%0d exp=0", bus.pkt_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
